// File: rtl/operand_seq_if.sv
// Operand/ALU sequencer bus: push-button inputs, ALU strobes and operand/result outputs.
// alu_start is a one-cycle request; alu_done is a one-cycle response strobe with alu_res valid alongside it.
interface operand_seq_if;
  logic [3:0]  btn;
  logic        go;
  logic [2:0]  op_sel;
  logic        alu_done;
  logic [31:0] alu_res;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic [31:0] res_out;
  logic        err;
  logic [2:0]  digit_sel;
  logic [7:0]  blink;
  logic [2:0]  state_out;

  modport slave (
    input  btn, go, op_sel, alu_done, alu_res,
    output a_out, b_out, alu_op, alu_start, res_out, err, digit_sel, blink, state_out
  );

  modport master (
    output btn, go, op_sel, alu_done, alu_res,
    input  a_out, b_out, alu_op, alu_start, res_out, err, digit_sel, blink, state_out
  );
endinterface

// File: rtl/operand_seq_ctrl.sv
// Push-button operand editor that issues one ALU operation, waits for completion
// with a 256-cycle timeout, and shows the result.
module operand_seq_ctrl (
  input  logic clk,
  input  logic rst_n,
  operand_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_EDIT_A = 3'd0,
    S_EDIT_B = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  sync1_q, sync2_q, prev_q;
  logic [2:0]  arm_q;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]  op_q, op_d, dsel_q, dsel_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  blink_q, blink_d;

  logic [4:0]  raw;
  logic [4:0]  edge_w;
  logic        act_next, act_prev, act_inc, act_dec, act_go;
  logic [4:0]  nib_lo;
  logic        edit_st;

  assign raw = {bus.go, bus.btn};

  // Edges stay masked until the synchronizer and previous-value stages have
  // refilled after reset, so a button held through reset never fires.
  assign edge_w = sync2_q & ~prev_q & {5{arm_q[2]}};

  assign act_next = edge_w[0];
  assign act_prev = edge_w[1] & ~edge_w[0];
  assign act_inc  = edge_w[2] & ~|edge_w[1:0];
  assign act_dec  = edge_w[3] & ~|edge_w[2:0];
  assign act_go   = edge_w[4] & ~|edge_w[3:0];
  assign nib_lo   = {dsel_q, 2'b00};
  assign edit_st  = (state_q == S_EDIT_A) || (state_q == S_EDIT_B) || (state_q == S_SHOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= {arm_q[1:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    dsel_d  = dsel_q;
    cnt_d   = cnt_q;
    if (edit_st) begin
      if (act_next) dsel_d = dsel_q + 3'd1;
      if (act_prev) dsel_d = dsel_q - 3'd1;
    end
    case (state_q)
      S_EDIT_A: begin
        if (act_inc) a_d[nib_lo +: 4] = a_q[nib_lo +: 4] + 4'd1;
        if (act_dec) a_d[nib_lo +: 4] = a_q[nib_lo +: 4] - 4'd1;
        if (act_go) begin
          state_d = S_EDIT_B;
          dsel_d  = 3'd0;
        end
      end
      S_EDIT_B: begin
        if (act_inc) b_d[nib_lo +: 4] = b_q[nib_lo +: 4] + 4'd1;
        if (act_dec) b_d[nib_lo +: 4] = b_q[nib_lo +: 4] - 4'd1;
        if (act_go) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        op_d    = bus.op_sel;
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done strobe in the final timeout cycle still delivers its result.
        if (bus.alu_done) begin
          res_d   = bus.alu_res;
          err_d   = 1'b0;
          state_d = S_SHOW;
        end else if (cnt_q == 8'hFF) begin
          res_d   = 32'd0;
          err_d   = 1'b1;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHOW: begin
        if (act_go) begin
          state_d = S_EDIT_A;
          err_d   = 1'b0;
          dsel_d  = 3'd0;
        end
      end
      default: state_d = S_EDIT_A;
    endcase
    blink_d = 8'h00;
    if ((state_d == S_EDIT_A) || (state_d == S_EDIT_B) || (state_d == S_SHOW))
      blink_d = 8'h01 << dsel_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EDIT_A;
      a_q     <= 32'h87654321;
      b_q     <= 32'h12345678;
      op_q    <= 3'd0;
      res_q   <= 32'd0;
      err_q   <= 1'b0;
      dsel_q  <= 3'd0;
      cnt_q   <= 8'd0;
      blink_q <= 8'h01;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      dsel_q  <= dsel_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_start = (state_q == S_ISSUE);
  assign bus.res_out   = res_q;
  assign bus.err       = err_q;
  assign bus.digit_sel = dsel_q;
  assign bus.blink     = blink_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Directed bench for operand_seq_ctrl: edit, issue, completion, timeout and reset behaviour.
module tb_operand_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  operand_seq_if bus ();

  operand_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mask = {go, btn[3:0]}; held three cycles, then released long enough to clear the edge detector
  task automatic press(input logic [4:0] mask);
    bus.btn = mask[3:0];
    bus.go  = mask[4];
    tick(3);
    bus.btn = 4'd0;
    bus.go  = 1'b0;
    tick(3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {29'd0, bus.state_out}, 32'd0);
    chk({tag, "_a"},     bus.a_out, 32'h87654321);
    chk({tag, "_b"},     bus.b_out, 32'h12345678);
    chk({tag, "_res"},   bus.res_out, 32'd0);
    chk({tag, "_op"},    {29'd0, bus.alu_op}, 32'd0);
    chk({tag, "_start"}, {31'd0, bus.alu_start}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus.err}, 32'd0);
    chk({tag, "_dsel"},  {29'd0, bus.digit_sel}, 32'd0);
    chk({tag, "_blink"}, {24'd0, bus.blink}, 32'h01);
  endtask

  initial begin
    bus.btn = 4'd0;
    bus.go = 1'b0;
    bus.op_sel = 3'd0;
    bus.alu_done = 1'b0;
    bus.alu_res = 32'd0;

    // reset values
    tick(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick(5);

    // single inc: takes effect on the 3rd edge, no repeat while held
    bus.btn = 4'b0100;
    tick(2);
    chk("inc_early", bus.a_out, 32'h87654321);
    tick(1);
    chk("inc_3rd_edge", bus.a_out, 32'h87654322);
    chk("inc_blink", {24'd0, bus.blink}, 32'h01);
    tick(4);
    chk("inc_no_repeat", bus.a_out, 32'h87654322);
    bus.btn = 4'd0;
    tick(3);

    // nibble wrap without borrow/carry
    press(5'b01000);
    press(5'b01000);
    press(5'b01000);
    chk("dec_wrap", bus.a_out, 32'h8765432F);
    press(5'b00100);
    chk("inc_wrap", bus.a_out, 32'h87654320);
    press(5'b00010);
    chk("prev_wrap_dsel", {29'd0, bus.digit_sel}, 32'd7);
    chk("prev_wrap_blink", {24'd0, bus.blink}, 32'h80);
    press(5'b00001);
    chk("next_wrap_dsel", {29'd0, bus.digit_sel}, 32'd0);

    // simultaneous next + inc: next wins
    press(5'b00101);
    chk("prio_dsel", {29'd0, bus.digit_sel}, 32'd1);
    chk("prio_a", bus.a_out, 32'h87654320);
    chk("prio_blink", {24'd0, bus.blink}, 32'h02);
    press(5'b00100);
    chk("inc_digit1", bus.a_out, 32'h87654330);

    // go to EDIT_B, edit b
    press(5'b10000);
    chk("edit_b_state", {29'd0, bus.state_out}, 32'd1);
    chk("edit_b_dsel", {29'd0, bus.digit_sel}, 32'd0);
    press(5'b01000);
    chk("dec_b", bus.b_out, 32'h12345677);

    // issue with op_sel=2, complete with alu_done
    bus.op_sel = 3'd2;
    bus.go = 1'b1;
    tick(3);
    chk("issue_state", {29'd0, bus.state_out}, 32'd2);
    chk("issue_start", {31'd0, bus.alu_start}, 32'd1);
    bus.go = 1'b0;
    tick(1);
    chk("wait_state", {29'd0, bus.state_out}, 32'd3);
    chk("wait_start_low", {31'd0, bus.alu_start}, 32'd0);
    chk("wait_op", {29'd0, bus.alu_op}, 32'd2);
    chk("wait_blink", {24'd0, bus.blink}, 32'h00);
    bus.op_sel = 3'd5;
    bus.btn = 4'b0001;
    tick(3);
    bus.btn = 4'd0;
    chk("wait_a_stable", bus.a_out, 32'h87654330);
    chk("wait_op_stable", {29'd0, bus.alu_op}, 32'd2);
    bus.alu_done = 1'b1;
    bus.alu_res = 32'h99999999;
    tick(1);
    bus.alu_done = 1'b0;
    bus.alu_res = 32'h0;
    chk("show_state", {29'd0, bus.state_out}, 32'd4);
    chk("show_res", bus.res_out, 32'h99999999);
    chk("show_err", {31'd0, bus.err}, 32'd0);
    chk("show_dsel_wait_ignored", {29'd0, bus.digit_sel}, 32'd0);
    chk("show_blink", {24'd0, bus.blink}, 32'h01);

    // SHOW: inc ignored, prev works, go back to EDIT_A
    press(5'b00100);
    chk("show_inc_a", bus.a_out, 32'h87654330);
    chk("show_inc_b", bus.b_out, 32'h12345677);
    press(5'b00010);
    chk("show_prev_dsel", {29'd0, bus.digit_sel}, 32'd7);
    chk("show_prev_blink", {24'd0, bus.blink}, 32'h80);
    press(5'b10000);
    chk("back_a_state", {29'd0, bus.state_out}, 32'd0);
    chk("back_a_dsel", {29'd0, bus.digit_sel}, 32'd0);

    // timeout after exactly 256 WAIT cycles
    press(5'b10000);
    bus.go = 1'b1;
    tick(3);
    bus.go = 1'b0;
    chk("to_issue", {29'd0, bus.state_out}, 32'd2);
    tick(1);
    chk("to_op", {29'd0, bus.alu_op}, 32'd5);
    tick(255);
    chk("to_still_wait", {29'd0, bus.state_out}, 32'd3);
    tick(1);
    chk("to_state", {29'd0, bus.state_out}, 32'd4);
    chk("to_err", {31'd0, bus.err}, 32'd1);
    chk("to_res", bus.res_out, 32'd0);
    press(5'b10000);
    chk("to_back_state", {29'd0, bus.state_out}, 32'd0);
    chk("to_err_clr", {31'd0, bus.err}, 32'd0);

    // alu_done coincident with timeout wins
    press(5'b10000);
    bus.go = 1'b1;
    tick(3);
    bus.go = 1'b0;
    tick(1);
    tick(255);
    bus.alu_done = 1'b1;
    bus.alu_res = 32'h0000ABCD;
    tick(1);
    bus.alu_done = 1'b0;
    chk("coin_state", {29'd0, bus.state_out}, 32'd4);
    chk("coin_err", {31'd0, bus.err}, 32'd0);
    chk("coin_res", bus.res_out, 32'h0000ABCD);
    press(5'b10000);

    // reset mid-WAIT, later alu_done ignored
    press(5'b10000);
    bus.go = 1'b1;
    tick(3);
    bus.go = 1'b0;
    tick(5);
    chk("rw_in_wait", {29'd0, bus.state_out}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rw_async");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    bus.alu_done = 1'b1;
    bus.alu_res = 32'h55AA55AA;
    tick(1);
    bus.alu_done = 1'b0;
    tick(2);
    chk_reset_vals("rw_after_done");

    // button held across reset release must not fire
    rst_n = 1'b0;
    bus.btn = 4'b0001;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("held_no_fire", {29'd0, bus.digit_sel}, 32'd0);
    bus.btn = 4'd0;
    tick(3);
    press(5'b00001);
    chk("held_repress", {29'd0, bus.digit_sel}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
